// File: rtl/csla_seq_pkg.sv
// Shared types and helpers for the nibble-serial carry-select add sequencer.
package csla_seq_pkg;

  // Controller states: waiting for operands, stepping nibbles, holding the result
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } csla_seq_state_t;

  // Width of the shared carry-select adder slice
  localparam int CSLA_NIB_W = 4;

  // Number of adder passes needed for an operand of the given width
  function automatic int csla_nib_cnt(input int width);
    return width / CSLA_NIB_W;
  endfunction

endpackage

// File: rtl/csla_seq_ctrl_csla.sv
// 4-bit carry-select adder: the low pair ripples, the high pair is computed for
// both possible carries and the low-pair carry picks the right one.
module CSLA (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [2:0] loSum;
  logic [2:0] hiSum0;
  logic [2:0] hiSum1;
  logic [2:0] hiSel;

  // Both speculative upper halves are ready before the lower carry arrives
  always_comb begin
    loSum  = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
    hiSum0 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
    hiSum1 = {1'b0, a[3:2]} + {1'b0, b[3:2]} + 3'd1;
    hiSel  = loSum[2] ? hiSum1 : hiSum0;
    s      = {hiSel[1:0], loSum[1:0]};
    cout   = hiSel[2];
  end

endmodule

// File: rtl/csla_seq_ctrl.sv
// Wide adder built by stepping one shared 4-bit carry-select adder across the
// operands, least significant nibble first, with the carry held in a register.
// Optional feature macro: CSLA_SEQ_OVF_EN adds a registered signed-overflow flag.
module csla_seq_ctrl
  import csla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
`ifdef CSLA_SEQ_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int NIB   = csla_nib_cnt(WIDTH);
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH % CSLA_NIB_W) != 0 || WIDTH < CSLA_NIB_W) begin : gWidthCheck
    $error("csla_seq_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  csla_seq_state_t  state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef CSLA_SEQ_OVF_EN
  logic             ovf_q, ovf_d;
  logic             cMsb;
`endif

  logic [CSLA_NIB_W-1:0] nibA;
  logic [CSLA_NIB_W-1:0] nibB;
  logic [CSLA_NIB_W-1:0] nibS;
  logic                  nibCout;
  logic                  lastNib;

  assign nibA    = opA_q[CSLA_NIB_W*idx_q +: CSLA_NIB_W];
  assign nibB    = opB_q[CSLA_NIB_W*idx_q +: CSLA_NIB_W];
  assign lastNib = (idx_q == IDX_W'(NIB - 1));

  CSLA uAdder (
    .a    (nibA),
    .b    (nibB),
    .cin  (carry_q),
    .s    (nibS),
    .cout (nibCout)
  );

`ifdef CSLA_SEQ_OVF_EN
  // Carry into the sign bit, recovered from the top-nibble sum bit
  assign cMsb = opA_q[WIDTH-1] ^ opB_q[WIDTH-1] ^ nibS[CSLA_NIB_W-1];
`endif

  // Next-state logic: capture operands, step one nibble per cycle, hold until taken
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef CSLA_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opA_d   = in_a;
          opB_d   = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[CSLA_NIB_W*idx_q +: CSLA_NIB_W] = nibS;
        carry_d = nibCout;
        if (lastNib) begin
          cout_d  = nibCout;
`ifdef CSLA_SEQ_OVF_EN
          ovf_d   = cMsb ^ nibCout;
`endif
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      opA_q   <= '0;
      opB_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef CSLA_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef CSLA_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
`ifdef CSLA_SEQ_OVF_EN
  assign out_ovf   = ovf_q;
`endif

endmodule
